// File: rtl/branch_update_sequencer_if.sv
// Predictor training bus: prediction push, in-order resolve, predictor drive and statistics.
// The sequencer takes the slave modport; the issuing/resolving side takes master.
interface branch_update_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 10,
  parameter int CNT_W = 16
);
  logic                     PUSH_VALID;
  logic                     PUSH_READY;
  logic [IDX_W-1:0]         PUSH_IDX;
  logic                     PUSH_PRED;
  logic                     RES_VALID;
  logic                     RES_READY;
  logic                     RES_TAKEN;
  logic [IDX_W-1:0]         UPD_IDX;
  logic                     UPD_TAKEN;
  logic                     UPDATE;
  logic                     MISPREDICT;
  logic [$clog2(DEPTH):0]   OCCUPANCY;
  logic [CNT_W-1:0]         RES_CNT;
  logic [CNT_W-1:0]         MISS_CNT;
  logic                     UNDERFLOW;

  modport master (
    output PUSH_VALID, PUSH_IDX, PUSH_PRED, RES_VALID, RES_TAKEN,
    input  PUSH_READY, RES_READY, UPD_IDX, UPD_TAKEN, UPDATE, MISPREDICT,
    input  OCCUPANCY, RES_CNT, MISS_CNT, UNDERFLOW
  );

  modport slave (
    input  PUSH_VALID, PUSH_IDX, PUSH_PRED, RES_VALID, RES_TAKEN,
    output PUSH_READY, RES_READY, UPD_IDX, UPD_TAKEN, UPDATE, MISPREDICT,
    output OCCUPANCY, RES_CNT, MISS_CNT, UNDERFLOW
  );
endinterface

// File: rtl/branch_update_sequencer.sv
// In-order prediction queue that trains saturating-counter predictors with a
// setup-then-strobe sequence, flushing younger entries on a mispredict.
module branch_update_sequencer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 10,
  parameter int CNT_W = 16
) (
  input logic                     CLK,
  input logic                     RESET,
  branch_update_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t             state_r, state_next_s;
  logic [IDX_W-1:0]   idx_mem_r [DEPTH];
  logic [DEPTH-1:0]   pred_mem_r;
  logic [PTR_W-1:0]   head_r, tail_r;
  logic [PTR_W:0]     occ_r;
  logic [IDX_W-1:0]   upd_idx_r;
  logic               upd_taken_r, update_r, mispredict_r, underflow_r;
  logic [CNT_W-1:0]   res_cnt_r, miss_cnt_r;
  logic               push_ready_s, res_ready_s, push_s, accept_s, mispredict_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) sat_inc = v;
    else              sat_inc = v + CNT_ONE;
  endfunction

  assign push_ready_s = (occ_r < OCC_FULL);
  assign res_ready_s  = (state_r == IDLE) && (occ_r != '0);
  assign push_s       = bus.PUSH_VALID && push_ready_s;
  assign accept_s     = bus.RES_VALID && res_ready_s;
  assign mispredict_s = accept_s && (pred_mem_r[head_r] != bus.RES_TAKEN);

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next state: a single setup cycle, then a single strobe cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_next_s = SETUP; else state_next_s = IDLE;
      SETUP:   state_next_s = STROBE;
      STROBE:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Queue storage, written at the tail on an accepted push
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) idx_mem_r[i] <= '0;
      pred_mem_r <= '0;
    end else if (push_s && !mispredict_s) begin
      idx_mem_r[tail_r]  <= bus.PUSH_IDX;
      pred_mem_r[tail_r] <= bus.PUSH_PRED;
    end else begin
      pred_mem_r <= pred_mem_r;
    end
  end

  // Pointers and occupancy; a mispredict empties the queue and drops a same-cycle push
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= '0;
    end else if (mispredict_s) begin
      head_r <= tail_r;
      occ_r  <= '0;
    end else begin
      if (accept_s) head_r <= head_r + PTR_ONE;
      if (push_s)   tail_r <= tail_r + PTR_ONE;
      case ({push_s, accept_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Predictor drive and status; UPDATE is registered so it only rises after a setup cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      upd_idx_r    <= '0;
      upd_taken_r  <= 1'b0;
      update_r     <= 1'b0;
      mispredict_r <= 1'b0;
      underflow_r  <= 1'b0;
      res_cnt_r    <= '0;
      miss_cnt_r   <= '0;
    end else begin
      update_r     <= (state_next_s == STROBE);
      mispredict_r <= mispredict_s;
      if (accept_s) begin
        upd_idx_r   <= idx_mem_r[head_r];
        upd_taken_r <= bus.RES_TAKEN;
        res_cnt_r   <= sat_inc(res_cnt_r);
      end
      if (mispredict_s) miss_cnt_r <= sat_inc(miss_cnt_r);
      if (bus.RES_VALID && (state_r == IDLE) && (occ_r == '0)) underflow_r <= 1'b1;
    end
  end

  assign bus.PUSH_READY = push_ready_s;
  assign bus.RES_READY  = res_ready_s;
  assign bus.UPD_IDX    = upd_idx_r;
  assign bus.UPD_TAKEN  = upd_taken_r;
  assign bus.UPDATE     = update_r;
  assign bus.MISPREDICT = mispredict_r;
  assign bus.OCCUPANCY  = occ_r;
  assign bus.RES_CNT    = res_cnt_r;
  assign bus.MISS_CNT   = miss_cnt_r;
  assign bus.UNDERFLOW  = underflow_r;
endmodule

// File: tb/tb_branch_update_sequencer.sv
// Directed bench for branch_update_sequencer (DEPTH=8, IDX_W=10, CNT_W=4 so saturation is reachable).
module tb_branch_update_sequencer;
  localparam int DEPTH = 8;
  localparam int IDX_W = 10;
  localparam int CNT_W = 4;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;
  int   exp_res;
  int   exp_miss;

  branch_update_sequencer_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  branch_update_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; inputs released and outputs sampled 1ns after the edge
  task automatic cyc(input logic pv, input logic [IDX_W-1:0] pidx, input logic ppred,
                     input logic rv, input logic rt);
    bus.PUSH_VALID = pv;
    bus.PUSH_IDX   = pidx;
    bus.PUSH_PRED  = ppred;
    bus.RES_VALID  = rv;
    bus.RES_TAKEN  = rt;
    @(posedge CLK);
    #1;
    bus.PUSH_VALID = 1'b0;
    bus.RES_VALID  = 1'b0;
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input logic pred);
    cyc(1'b1, idx, pred, 1'b0, 1'b0);
  endtask

  // Resolve the head and follow it through SETUP, STROBE and back to IDLE
  task automatic resolve_chk(input logic rt, input logic [IDX_W-1:0] exp_idx, input logic exp_mis,
                             input logic pv, input logic [IDX_W-1:0] pidx, input logic ppred,
                             input int exp_occ);
    cyc(pv, pidx, ppred, 1'b1, rt);
    if (exp_res < 15) exp_res++;
    if (exp_mis && exp_miss < 15) exp_miss++;
    check("setup_idx", 32'(bus.UPD_IDX), 32'(exp_idx));
    check("setup_taken", 32'(bus.UPD_TAKEN), 32'(rt));
    check("setup_update", 32'(bus.UPDATE), 32'd0);
    check("setup_mispredict", 32'(bus.MISPREDICT), 32'(exp_mis));
    check("setup_occ", 32'(bus.OCCUPANCY), 32'(exp_occ));
    check("setup_res_ready", 32'(bus.RES_READY), 32'd0);
    check("res_cnt", 32'(bus.RES_CNT), 32'(exp_res));
    check("miss_cnt", 32'(bus.MISS_CNT), 32'(exp_miss));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("strobe_update", 32'(bus.UPDATE), 32'd1);
    check("strobe_mispredict", 32'(bus.MISPREDICT), 32'd0);
    check("strobe_idx_hold", 32'(bus.UPD_IDX), 32'(exp_idx));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("idle_update", 32'(bus.UPDATE), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_res  = 0;
    exp_miss = 0;
    bus.PUSH_VALID = 1'b0;
    bus.PUSH_IDX   = '0;
    bus.PUSH_PRED  = 1'b0;
    bus.RES_VALID  = 1'b0;
    bus.RES_TAKEN  = 1'b0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset state
    check("rst_occ", 32'(bus.OCCUPANCY), 32'd0);
    check("rst_push_ready", 32'(bus.PUSH_READY), 32'd1);
    check("rst_res_ready", 32'(bus.RES_READY), 32'd0);
    check("rst_update", 32'(bus.UPDATE), 32'd0);
    check("rst_mispredict", 32'(bus.MISPREDICT), 32'd0);
    check("rst_res_cnt", 32'(bus.RES_CNT), 32'd0);
    check("rst_miss_cnt", 32'(bus.MISS_CNT), 32'd0);
    check("rst_underflow", 32'(bus.UNDERFLOW), 32'd0);
    check("rst_upd_idx", 32'(bus.UPD_IDX), 32'd0);

    // Single correct prediction
    push(10'h005, 1'b1);
    check("t2_occ", 32'(bus.OCCUPANCY), 32'd1);
    check("t2_res_ready", 32'(bus.RES_READY), 32'd1);
    resolve_chk(1'b1, 10'h005, 1'b0, 1'b0, '0, 1'b0, 0);

    // Mispredict flushes younger entries
    push(10'h011, 1'b1);
    push(10'h022, 1'b0);
    push(10'h033, 1'b1);
    check("t3_occ", 32'(bus.OCCUPANCY), 32'd3);
    resolve_chk(1'b0, 10'h011, 1'b1, 1'b0, '0, 1'b0, 0);

    // Push alongside a mispredicting accept is dropped
    push(10'h044, 1'b1);
    resolve_chk(1'b0, 10'h044, 1'b1, 1'b1, 10'h055, 1'b1, 0);

    // Push alongside a correct accept keeps occupancy
    push(10'h066, 1'b0);
    resolve_chk(1'b0, 10'h066, 1'b0, 1'b1, 10'h077, 1'b1, 1);
    resolve_chk(1'b1, 10'h077, 1'b0, 1'b0, '0, 1'b0, 0);

    // Fill, overflow attempt, push during pop at full, drain in order with wrap
    for (int i = 0; i < DEPTH; i++) push(IDX_W'(10'h100 + i), i[0]);
    check("t4_full_occ", 32'(bus.OCCUPANCY), 32'd8);
    check("t4_full_ready", 32'(bus.PUSH_READY), 32'd0);
    push(10'h3ff, 1'b1);
    check("t4_overflow_occ", 32'(bus.OCCUPANCY), 32'd8);
    resolve_chk(1'b0, 10'h100, 1'b0, 1'b1, 10'h3fe, 1'b1, 7);
    for (int i = 1; i < DEPTH; i++)
      resolve_chk(i[0], IDX_W'(10'h100 + i), 1'b0, 1'b0, '0, 1'b0, DEPTH - 1 - i);
    check("t4_drained_ready", 32'(bus.PUSH_READY), 32'd1);

    // Underflow is sticky and has no other effect
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("t5_underflow", 32'(bus.UNDERFLOW), 32'd1);
    check("t5_res_cnt", 32'(bus.RES_CNT), 32'(exp_res));
    check("t5_update", 32'(bus.UPDATE), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t5_update_later", 32'(bus.UPDATE), 32'd0);
    check("t5_state_idle", 32'(bus.RES_READY), 32'd0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t5_sticky", 32'(bus.UNDERFLOW), 32'd1);

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      push(IDX_W'(10'h200 + i), 1'b1);
      resolve_chk(1'b1, IDX_W'(10'h200 + i), 1'b0, 1'b0, '0, 1'b0, 0);
    end
    check("t6_res_sat", 32'(bus.RES_CNT), 32'd15);

    // Reset in the middle of a strobe
    push(10'h0aa, 1'b1);
    push(10'h0bb, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t1_pre_update", 32'(bus.UPDATE), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("t1_update", 32'(bus.UPDATE), 32'd0);
    check("t1_occ", 32'(bus.OCCUPANCY), 32'd0);
    check("t1_res_cnt", 32'(bus.RES_CNT), 32'd0);
    check("t1_miss_cnt", 32'(bus.MISS_CNT), 32'd0);
    check("t1_underflow", 32'(bus.UNDERFLOW), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t1_no_update", 32'(bus.UPDATE), 32'd0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_update_sequencer.md
Name: branch_update_sequencer

Overview:
- Producer side of the predictor training interface: queues issued predictions in order.
- Pairs each queued prediction with its in-order branch resolution.
- Drives the saturating-counter predictors' TAKEN/UPDATE/index lines, sequenced so TAKEN is stable before UPDATE rises.
- Detects mispredicts, flushes younger queued predictions, and keeps resolve and mispredict statistics.

Parameters:
DEPTH, 8, prediction queue entries (power of two, >=2)
IDX_W, 10, predictor table index width
CNT_W, 16, statistics counter width

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-high reset
PUSH_VALID  in  1  issue a prediction
PUSH_READY  out  1  queue not full (combinational from occupancy)
PUSH_IDX  in  IDX_W  predictor index used for the prediction
PUSH_PRED  in  1  predicted direction (1 = taken)
RES_VALID  in  1  oldest outstanding branch resolved
RES_READY  out  1  sequencer in IDLE and queue not empty
RES_TAKEN  in  1  actual direction
UPD_IDX  out  IDX_W  index of the predictor to train
UPD_TAKEN  out  1  TAKEN value presented to the predictor
UPDATE  out  1  training strobe; predictors act on its rising edge
MISPREDICT  out  1  one-cycle pulse: head prediction was wrong, queue flushed
OCCUPANCY  out  clog2(DEPTH)+1  entries held
RES_CNT  out  CNT_W  accepted resolves, saturating
MISS_CNT  out  CNT_W  mispredicts, saturating
UNDERFLOW  out  1  sticky: RES_VALID seen while queue empty

Behaviour:
- Reset (async, immediate): queue empty, pointers 0, FSM IDLE, all outputs 0. UPDATE drops at once even mid-strobe, so no predictor edge is produced.
- Queue: circular buffer of {IDX, PRED}.
  - Push accepted when PUSH_VALID & PUSH_READY; written at the tail.
  - Pointers wrap modulo DEPTH.
  - PUSH_READY = OCCUPANCY < DEPTH.
- Resolve accept: RES_VALID & RES_READY. Pops the head and moves the FSM IDLE -> SETUP.
- FSM, three states, one resolve per 3 cycles max:
  - IDLE: UPDATE=0; RES_READY = (OCCUPANCY != 0).
  - SETUP: lasts 1 cycle. UPD_IDX = head IDX and UPD_TAKEN = RES_TAKEN, both registered at accept. UPDATE=0 here, giving one cycle of setup before the edge.
  - STROBE: lasts 1 cycle; UPDATE=1. Then back to IDLE, where UPDATE returns to 0.
  - UPD_IDX/UPD_TAKEN hold their values until the next accept.
- Mispredict = head PRED != RES_TAKEN at accept.
  - MISPREDICT pulses during SETUP.
  - The queue is cleared in the accept cycle (all younger entries discarded); OCCUPANCY reads 0 in SETUP.
  - A push in the same cycle as a mispredicting accept is discarded.
- Correct prediction with simultaneous push and accept: OCCUPANCY unchanged.
- Counters:
  - RES_CNT increments on each accept.
  - MISS_CNT increments on each mispredict.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Underflow: RES_VALID while OCCUPANCY==0 in IDLE sets UNDERFLOW. The resolve is ignored and no counter changes. UNDERFLOW is cleared only by RESET.
- RES_VALID in SETUP or STROBE: RES_READY is 0, so the resolve is not accepted. The source must hold it; no underflow is flagged.
- Full: push while full is ignored and the queue is unchanged. A push in the cycle a resolve pops still sees PUSH_READY=0 (based on pre-pop occupancy).

Test Plan:
1. RESET pulse mid-STROBE (UPDATE=1) -> UPDATE=0 within the same cycle, OCCUPANCY=0, counters 0, no further UPDATE.
2. Push {IDX=0x05,PRED=1}, resolve TAKEN=1 -> SETUP cycle: UPD_IDX=0x05, UPD_TAKEN=1, UPDATE=0. Next cycle UPDATE=1, then 0. RES_CNT=1, MISS_CNT=0, no MISPREDICT.
3. Push 3 entries (PRED=1,0,1), resolve head with TAKEN=0 -> MISPREDICT pulse in SETUP, OCCUPANCY=0, MISS_CNT=1, UPD_TAKEN=0, UPD_IDX=first index.
4. Push 8 entries with DEPTH=8 -> PUSH_READY=0 and a 9th push is ignored. Resolve all 8 correctly -> 8 UPDATE strobes in push order, pointers wrap, OCCUPANCY returns to 0, RES_CNT=8.
5. RES_VALID with empty queue -> UNDERFLOW=1 and stays set. RES_CNT unchanged, no UPDATE.
6. With CNT_W=4, perform 20 correct resolves -> RES_CNT saturates at 15.
